hamming_seq_unit: RTL
=====================

// Module: hamming_seq_unit
// PURPOSE
//  Multi-cycle, parametrised Hamming unit for the MIPS32 datapath. Successor to the
//  fixed 32-bit combinational bit-count: counts set bits of A (weight), of A^B
//  (distance), parity, or zero count, CHUNK bits per clock. Sits behind the ALU
//  as a variable-latency functional unit with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of CHUNK
//  CHUNK  8   bits counted per RUN cycle; RUN length N = WIDTH/CHUNK
//  RES_W  32  result width; count is zero-extended to RES_W
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B (used by DIST only)
//  mode       in   2      00 WEIGHT, 01 DIST, 10 PARITY, 11 ZEROS
//  clr        in   1      synchronous abort, returns to IDLE
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  result     out  RES_W  count/parity, zero-extended
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0,
//   accumulator, shift register, counter and mode register all 0. Reset mid-RUN or
//   mid-DONE discards the operation; no result is emitted.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready: sr <= (mode==01) ? op_a^op_b : op_a;
//   mode latched; acc <= 0; cnt <= N-1; go RUN. Inputs are sampled only here.
//  RUN: each cycle acc += popcount(sr[CHUNK-1:0]); sr >>= CHUNK; cnt--.
//   After the cycle where cnt==0, go DONE. Exactly N RUN cycles.
//  DONE: out_valid=1; result is stable and held until out_valid&out_ready,
//   then go IDLE. in_ready=0 in DONE: no same-cycle re-accept (one bubble).
//  Latency: out_valid rises N+1 clocks after the accepting edge (4+1 = 5 at defaults).
//  Throughput: one op per N+2 clocks with out_ready held high.
//  Result: acc width = $clog2(WIDTH+1) bits, never overflows (max WIDTH).
//   WEIGHT/DIST -> acc; PARITY -> acc[0]; ZEROS -> WIDTH-acc. Upper bits 0.
//  result is registered, updated only on entry to DONE; it holds the last value in
//   IDLE and RUN. It is cleared only by rst_n.
//  clr: in any state, next state IDLE, out_valid=0; result keeps its last value.
//   clr wins over a simultaneous in_valid accept or out_ready handshake.
//  in_valid while not in IDLE is ignored (no queuing).
//  WIDTH % CHUNK != 0 or CHUNK > WIDTH: elaboration-time $error.
// STRUCTURE
//  Shared package hamming_pkg: mode encodings HM_WEIGHT/HM_DIST/HM_PARITY/
//   HM_ZEROS (2-bit) and state encodings HS_IDLE/HS_RUN/HS_DONE.
//  Sub-module hamming_chunk_count #(CHUNK): combinational popcount of CHUNK bits,
//   output $clog2(CHUNK+1) bits. Generalises the existing 8-bit count cell.
//  Top: FSM, shift register, down-counter, accumulator, result mux/register.
// TESTING
//  1 WEIGHT a=32'hFFFF_FFFF -> out_valid 5 clk after accept, result=32.
//  2 DIST a=32'hF0F0_F0F0 b=32'h0F0F_0F0F -> 32. Same a and b -> 0.
//  3 PARITY a=32'h0000_0007 -> 1; ZEROS a=32'h0000_0001 -> 31.
//  4 Backpressure: out_ready=0 for 6 clk after out_valid -> result stable at its
//    value, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next clk.
//  5 rst_n low for 1 clk after 2 RUN cycles -> out_valid=0, in_ready=1, result=0.
//    clr at the same point -> IDLE next clk, no out_valid.
//  6 WIDTH=64, CHUNK=16, a=64'h8000_0000_0000_0001 WEIGHT -> 2 after 4 RUN clk.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared encodings for the sequential Hamming unit: operation modes and FSM states.
package hamming_pkg;

  typedef enum logic [1:0] {
    HM_WEIGHT = 2'b00,
    HM_DIST   = 2'b01,
    HM_PARITY = 2'b10,
    HM_ZEROS  = 2'b11
  } hm_mode_e;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_RUN  = 2'd1,
    HS_DONE = 2'd2
  } hs_state_e;

endpackage

// File: rtl/hamming_chunk_count.sv
// Combinational popcount of one CHUNK-bit slice; zero latency, no flow control.
module hamming_chunk_count #(
  parameter int CHUNK = 8,
  parameter int CNT_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/hamming_seq_unit.sv
// Multi-cycle weight/distance/parity/zero-count unit, CHUNK bits per clock.
// Latency N+1 cycles from the accept cycle (N = WIDTH/CHUNK); result held in DONE until out_ready.
module hamming_seq_unit
  import hamming_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int ACC_W = $clog2(WIDTH + 1);
  localparam int CC_W  = $clog2(CHUNK + 1);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH) begin : g_bad_params
      $error("hamming_seq_unit: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  hs_state_e        state_q, state_d;
  hm_mode_e         mode_q;
  logic [WIDTH-1:0] sr_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CC_W-1:0]  chunk_cnt;
  logic [ACC_W-1:0] acc_sum;
  logic [RES_W-1:0] res_next;
  logic             accept, step, finish;

  hamming_chunk_count #(
    .CHUNK (CHUNK),
    .CNT_W (CC_W)
  ) u_chunk (
    .bits  (sr_q[CHUNK-1:0]),
    .count (chunk_cnt)
  );

  // Includes the chunk counted this cycle so the final RUN cycle feeds the result directly.
  assign acc_sum = acc_q + ACC_W'(chunk_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      HS_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = HS_RUN;
        end
      end
      HS_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = HS_DONE;
        end
      end
      HS_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = HS_IDLE;
      end
      default: state_d = HS_IDLE;
    endcase
    // Abort overrides any accept, step or completion in the same cycle.
    if (clr) begin
      state_d = HS_IDLE;
      accept  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
    end
  end

  always_comb begin
    res_next = '0;
    case (mode_q)
      HM_WEIGHT, HM_DIST: res_next = RES_W'(acc_sum);
      HM_PARITY:          res_next = RES_W'(acc_sum[0]);
      HM_ZEROS:           res_next = RES_W'(ACC_W'(WIDTH) - acc_sum);
      default:            res_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= HM_WEIGHT;
      result <= '0;
    end else begin
      if (accept) begin
        sr_q   <= (hm_mode_e'(mode) == HM_DIST) ? (op_a ^ op_b) : op_a;
        mode_q <= hm_mode_e'(mode);
        acc_q  <= '0;
        cnt_q  <= CNT_W'(N - 1);
      end else if (step) begin
        sr_q  <= sr_q >> CHUNK;
        acc_q <= acc_sum;
        cnt_q <= cnt_q - 1'b1;
      end
      if (finish) result <= res_next;
    end
  end

endmodule
